lzss_decoder: RTL and testbench

Streaming LZSS decompressor. It consumes the (WORD_SIZE+1)-bit token stream produced by the team's LZSS encoder and reconstructs the original WORD_SIZE-bit byte stream. Literals pass straight through. Back-references are expanded one byte per cycle from a WINDOW_SIZE-deep history shift register. It sits on the receive side of the compression link, with valid/ready handshakes on both ports.

---
 rtl/lzss_decoder_if.sv | 23 ++
 rtl/lzss_decoder.sv | 107 ++++++++++
 tb/tb_lzss_decoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lzss_decoder_if.sv
// Token-in / word-out handshake bundle for lzss_decoder.
interface lzss_decoder_if #(
  parameter int WORD_SIZE = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE:0]   data_i;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] data_o;
  logic                 busy;
  logic                 err_o;

  modport slave (
    input  in_valid, data_i, out_ready,
    output in_ready, out_valid, data_o, busy, err_o
  );

  modport master (
    output in_valid, data_i, out_ready,
    input  in_ready, out_valid, data_o, busy, err_o
  );
endinterface

// File: rtl/lzss_decoder.sv
// Streaming LZSS decompressor: literals pass through, back-references expand from a shift-register history.
// Optional macro LZSS_DECODER_RANGE_CHECK_EN enables a fill counter and sticky err_o on out-of-range offsets.
module lzss_decoder #(
  parameter int WORD_SIZE   = 8,
  parameter int WINDOW_SIZE = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  lzss_decoder_if.slave  bus
);
  localparam int OFFSET_BITS = $clog2(WINDOW_SIZE);
  localparam int LENGTH_BITS = WORD_SIZE - OFFSET_BITS;

  typedef enum logic {IDLE, COPY} state_t;

  state_t                 state, state_next;
  logic [WORD_SIZE-1:0]   hist [WINDOW_SIZE];
  logic [WORD_SIZE-1:0]   data_q, load_word;
  logic                   out_valid_q, slot_free, in_ready, accept, load, is_ref, start_copy;
  logic [OFFSET_BITS-1:0] offset_q, tok_off;
  logic [LENGTH_BITS-1:0] remaining, tok_len;

  assign is_ref     = bus.data_i[WORD_SIZE];
  assign tok_off    = bus.data_i[WORD_SIZE-1:LENGTH_BITS];
  assign tok_len    = bus.data_i[LENGTH_BITS-1:0];
  assign slot_free  = !out_valid_q || bus.out_ready;
  assign in_ready   = rst_n && (state == IDLE) && slot_free;
  assign accept     = bus.in_valid && in_ready;
  assign start_copy = accept && is_ref && (tok_len != '0);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.data_o    = data_q;
  assign bus.busy      = (state == COPY);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_word  = bus.data_i[WORD_SIZE-1:0];
    case (state)
      IDLE: begin
        if (accept && !is_ref) load = 1'b1;
        if (start_copy)        state_next = COPY;
      end
      COPY: begin
        load_word = hist[offset_q];
        if (slot_free) begin
          load = 1'b1;
          if (remaining == LENGTH_BITS'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every loaded word enters hist[0]; the offset stays fixed so overlapping copies replay themselves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      offset_q    <= '0;
      remaining   <= '0;
      for (int unsigned i = 0; i < WINDOW_SIZE; i++) hist[i] <= '0;
    end else begin
      if (load) begin
        data_q      <= load_word;
        out_valid_q <= 1'b1;
        hist[0]     <= load_word;
        for (int unsigned i = 1; i < WINDOW_SIZE; i++) hist[i] <= hist[i-1];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (start_copy) begin
        offset_q  <= tok_off;
        remaining <= tok_len;
      end else if (state == COPY && slot_free) begin
        remaining <= remaining - LENGTH_BITS'(1);
      end
    end
  end

`ifdef LZSS_DECODER_RANGE_CHECK_EN
  logic [OFFSET_BITS:0] fill;
  logic                 err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill  <= '0;
      err_q <= 1'b0;
    end else begin
      if (load && fill != (OFFSET_BITS+1)'(WINDOW_SIZE)) fill <= fill + (OFFSET_BITS+1)'(1);
      if (start_copy && {1'b0, tok_off} >= fill) err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lzss_decoder.sv
// Directed bench for lzss_decoder (WORD_SIZE=8, WINDOW_SIZE=32).
module tb_lzss_decoder;
`ifdef LZSS_DECODER_RANGE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  lzss_decoder_if #(.WORD_SIZE(8)) bus ();

  lzss_decoder #(.WORD_SIZE(8), .WINDOW_SIZE(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Records every word handed downstream.
  always @(negedge clk)
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) q.push_back(bus.data_o);

  // Called and returns at posedge+1; holds the token until accepted.
  task automatic send(input logic [8:0] tok);
    bus.data_i   = tok;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    $display("FAIL send_timeout: token %h never accepted, in_ready %b, required 1", tok, bus.in_ready);
    $fatal(1, "handshake stuck");
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 100 && q.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.data_i = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0)  $display("FAIL rst_in_ready: got %b, expected 0", bus.in_ready);   else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, expected 0", bus.out_valid); else passed++;
    checks++; if (bus.data_o !== 8'h00)   $display("FAIL rst_data_o: got %h, expected 00", bus.data_o);      else passed++;
    checks++; if (bus.busy !== 1'b0)      $display("FAIL rst_busy: got %b, expected 0", bus.busy);           else passed++;
    checks++; if (bus.err_o !== 1'b0)     $display("FAIL rst_err: got %b, expected 0", bus.err_o);           else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1)  $display("FAIL rst_release_ready: got %b, expected 1", bus.in_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_literal_copy;
    logic [7:0] exp[6] = '{8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42};
    q.delete();
    send(9'h041); send(9'h042); send(9'h10C);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
        $display("FAIL copy_cycle%0d: in_ready/busy got %b/%b, expected 0/1", c, bus.in_ready, bus.busy); else passed++;
    end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL copy_done: in_ready/busy got %b/%b, expected 1/0", bus.in_ready, bus.busy); else passed++;
    wait_words(6);
    checks++; if (q.size() !== 6) $display("FAIL copy_count: got %0d, expected 6", q.size()); else passed++;
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      checks++; if (q[i] !== exp[i]) $display("FAIL copy_word%0d: got %h, expected %h", i, q[i], exp[i]); else passed++;
    end
    checks++; if (bus.err_o !== 1'b0) $display("FAIL copy_err: got %b, expected 0", bus.err_o); else passed++;
  endtask

  task automatic test_overlap;
    q.delete();
    send(9'h055); send(9'h107);
    wait_words(8);
    checks++; if (q.size() !== 8) $display("FAIL overlap_count: got %0d, expected 8", q.size()); else passed++;
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      checks++; if (q[i] !== 8'h55) $display("FAIL overlap_word%0d: got %h, expected 55", i, q[i]); else passed++;
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp[6] = '{8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42};
    q.delete();
    send(9'h041); send(9'h042); send(9'h10C);
    @(posedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.data_o !== 8'h42 || bus.out_valid !== 1'b1)
        $display("FAIL bp_hold%0d: data/valid got %h/%b, expected 42/1", c, bus.data_o, bus.out_valid); else passed++;
      checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b, expected 0", c, bus.in_ready); else passed++;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_words(6);
    checks++; if (q.size() !== 6) $display("FAIL bp_count: got %0d, expected 6", q.size()); else passed++;
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      checks++; if (q[i] !== exp[i]) $display("FAIL bp_word%0d: got %h, expected %h", i, q[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_null_token;
    q.delete();
    send(9'h010); send(9'h108); send(9'h020);
    wait_words(2);
    checks++; if (q.size() !== 2) $display("FAIL null_count: got %0d, expected 2", q.size()); else passed++;
    checks++; if (q.size() > 0 && q[0] !== 8'h10) $display("FAIL null_word0: got %h, expected 10", q[0]); else passed++;
    checks++; if (q.size() > 1 && q[1] !== 8'h20) $display("FAIL null_word1: got %h, expected 20", q[1]); else passed++;
  endtask

  task automatic test_range_check;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    send(9'h12A);
    @(negedge clk);
    checks++; if (bus.err_o !== EXP_ERR) $display("FAIL range_err: got %b, expected %b", bus.err_o, EXP_ERR); else passed++;
    wait_words(2);
    checks++; if (q.size() !== 2) $display("FAIL range_count: got %0d, expected 2", q.size()); else passed++;
    for (int i = 0; i < 2 && i < q.size(); i++) begin
      checks++; if (q[i] !== 8'h00) $display("FAIL range_word%0d: got %h, expected 00", i, q[i]); else passed++;
    end
    checks++; if (bus.err_o !== EXP_ERR) $display("FAIL range_sticky: got %b, expected %b", bus.err_o, EXP_ERR); else passed++;
  endtask

  task automatic test_reset_mid_copy;
    logic [7:0] exp[4] = '{8'h33, 8'h00, 8'h00, 8'h00};
    send(9'h055); send(9'h107);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid: got %b, expected 0", bus.out_valid); else passed++;
    checks++; if (bus.busy !== 1'b0)      $display("FAIL midrst_busy: got %b, expected 0", bus.busy);       else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    #1;
    checks++; if (bus.in_ready !== 1'b1)  $display("FAIL midrst_ready: got %b, expected 1", bus.in_ready); else passed++;
    @(posedge clk); #1;
    send(9'h033); send(9'h109); send(9'h119); send(9'h1F9);
    wait_words(4);
    checks++; if (q.size() !== 4) $display("FAIL midrst_count: got %0d, expected 4", q.size()); else passed++;
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      checks++; if (q[i] !== exp[i]) $display("FAIL midrst_word%0d: got %h, expected %h", i, q[i], exp[i]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_literal_copy();
    test_overlap();
    test_backpressure();
    test_null_token();
    test_range_check();
    test_reset_mid_copy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
